matrix_host_ctrl: RTL and testbench

- Host-side initiator for the 3x3 matrix multiplier's Load/Done handshake.
- Accepts a serial byte stream of 18 operands (A then B, row-major) and presents them to the multiplier as packed buses.
- Pulses Load, waits for the busy/done sequence, captures the 9 results and streams them back out with valid/ready flow control.
- Sits between the board I/O path (UART/switch loader) and the multiplier.

---
 rtl/matrix_host_ctrl.sv | 83 ++++++++
 tb/tb_matrix_host_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_host_ctrl.sv
// matrix_host_ctrl: collects 18 operand bytes, drives one Load/Done exchange with
// the 3x3 multiplier, then streams the 9 result bytes out with valid/ready.
module matrix_host_ctrl #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [71:0] A_flat,
  output logic [71:0] B_flat,
  output logic        mm_load,
  input  logic        mm_done,
  input  logic [71:0] res_flat,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {COLLECT, LOAD, WAIT_BUSY, WAIT_DONE, SEND} state_t;
  state_t state, state_nx;
  logic [4:0] in_cnt;
  logic [3:0] out_cnt;
  logic [TW-1:0] tmo;
  logic [71:0] res;
  logic in_hs, out_hs, tmo_hit, waiting;
  assign in_ready = state == COLLECT;
  assign in_hs = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign tmo_hit = tmo == TW'(TIMEOUT - 1);
  assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
  assign out_data = res[8*int'(out_cnt) +: 8];
  assign out_last = out_valid && out_cnt == 4'd8;
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT:   state_nx = in_hs && in_cnt == 5'd17 ? LOAD : COLLECT;
      LOAD:      state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = !mm_done ? WAIT_DONE : tmo_hit ? COLLECT : WAIT_BUSY;
      WAIT_DONE: state_nx = mm_done ? SEND : tmo_hit ? COLLECT : WAIT_DONE;
      SEND:      state_nx = out_hs && out_cnt == 4'd8 ? COLLECT : SEND;
      default:   state_nx = COLLECT;
    endcase
  end
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= COLLECT;
    else state <= state_nx;
  end
  // Registered outputs are loaded from the next state so they line up with it.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      tmo       <= '0;
      res       <= '0;
      A_flat    <= '0;
      B_flat    <= '0;
      mm_load   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mm_load   <= state_nx == LOAD;
      out_valid <= state_nx == SEND;
      busy      <= state_nx != COLLECT;
      tmo       <= waiting && state_nx == state ? tmo + 1'b1 : '0;
      err       <= err | (waiting && state_nx == COLLECT);
      if (in_hs) begin
        in_cnt <= in_cnt == 5'd17 ? 5'd0 : in_cnt + 5'd1;
        if (in_cnt < 5'd9) A_flat[8*int'(in_cnt) +: 8] <= in_data;
        else B_flat[8*(int'(in_cnt) - 9) +: 8] <= in_data;
      end
      if (state == WAIT_DONE && mm_done) begin
        res     <= res_flat;
        out_cnt <= '0;
      end else if (out_hs) out_cnt <= out_cnt == 4'd8 ? 4'd0 : out_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_matrix_host_ctrl.sv
// tb_matrix_host_ctrl: random and directed jobs against a matrix-product reference
// with a multiplier responder; a monitor pops expected result bytes from a scoreboard.
module tb_matrix_host_ctrl;
  logic clk = 0, Reset_n = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, mm_done = 1, out_ready = 1;
  logic [71:0] res_flat = 0;
  logic in_ready, mm_load, out_valid, out_last, busy, err;
  logic [71:0] A_flat, B_flat;
  logic [7:0] out_data;
  int n_chk = 0, n_pass = 0, jobs_in = 0, jobs_out = 0, n_out = 0, rmode = 0, pi = 0;
  bit hang = 0;
  logic [8:0] exp_q[$];
  logic [143:0] op_q[$];
  logic held = 0, pl = 0;
  logic [7:0] hd;
  logic [8:0] e;
  logic [143:0] op;
  logic [3:0] pat = 4'b1001;

  matrix_host_ctrl dut (.clk(clk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .A_flat(A_flat), .B_flat(B_flat), .mm_load(mm_load), .mm_done(mm_done),
    .res_flat(res_flat), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm, input string what);
    n_chk++;
    $display("FAIL %s: %s", nm, what);
  endtask

  // Reference: C = A*B with each element reduced mod 256.
  function automatic logic [71:0] matmul(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(a[8*(3*i+k) +: 8]) * int'(b[8*(3*k+j) +: 8]);
        r[8*(3*i+j) +: 8] = 8'(s % 256);
      end
    return r;
  endfunction

  function automatic logic [71:0] fill(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [71:0] rnd72();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Multiplier responder: Done drops a cycle after Load, 40 cycles busy, then results.
  initial forever begin
    @(negedge clk);
    if (mm_load && !hang && Reset_n) begin
      @(posedge clk); #1 mm_done = 0;
      repeat (40) @(posedge clk);
      #1 res_flat = matmul(A_flat, B_flat);
      mm_done = 1;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      1: begin out_ready = pat[pi % 4]; pi++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (!Reset_n) begin held = 0; pl = 0; continue; end
    if (held && out_valid) chk("out_stable", out_data, hd);
    held = out_valid && !out_ready;
    hd = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) fail("unexpected_out", $sformatf("got byte %0h, required none", out_data));
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[7:0]);
        chk("out_last", out_last, e[8]);
        n_out++;
        if (e[8]) jobs_out++;
      end
    end
    if (mm_load) begin
      chk("load_pulse", pl, 0);
      if (op_q.size() == 0) fail("unexpected_load", "got mm_load, required none");
      else begin
        op = op_q.pop_front();
        chk("A_flat", A_flat, op[143:72]);
        chk("B_flat", B_flat, op[71:0]);
      end
    end
    pl = mm_load;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1;
    in_data = b;
    do begin @(negedge clk); t++; end while (!in_ready && t < 5000);
    if (!in_ready) fail("in_ready_wait", "got in_ready=0 for 5000 cycles, required 1");
    else chk("holdoff", jobs_in, jobs_out);
    @(posedge clk); #1 in_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic run_job(input logic [71:0] a, input logic [71:0] b, input int gap);
    logic [71:0] r;
    r = matmul(a, b);
    op_q.push_back({a, b});
    if (!hang) for (int i = 0; i < 9; i++) exp_q.push_back({i == 8, r[8*i +: 8]});
    for (int i = 0; i < 9; i++) send_byte(a[8*i +: 8], gap);
    for (int i = 0; i < 9; i++) send_byte(b[8*i +: 8], gap);
    jobs_in++;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while ((exp_q.size() != 0 || busy) && t < 4000);
    if (exp_q.size() != 0 || busy) fail("idle_wait", $sformatf("got %0d bytes pending, required 0", exp_q.size()));
    else chk("busy_after", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    int t = 0;
    @(posedge clk); #2 Reset_n = 0;
    #1;
    chk("rst_mm_load", mm_load, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_A", A_flat, 0);
    chk("rst_B", B_flat, 0);
    chk("rst_in_ready", in_ready, 1);
    exp_q.delete();
    op_q.delete();
    jobs_out = jobs_in;
    repeat (3) @(negedge clk);
    Reset_n = 1;
    while (!mm_done && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, base;
    logic [71:0] id, seq;
    id = 72'h01_00_00_00_01_00_00_00_01;
    seq = 72'h09_08_07_06_05_04_03_02_01;
    repeat (3) @(negedge clk);
    chk("init_A", A_flat, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_err", err, 0);
    Reset_n = 1;
    @(negedge clk);
    chk("init_in_ready", in_ready, 1);
    chk("init_busy", busy, 0);
    @(posedge clk); #1;
    run_job(id, seq, 0); wait_idle();
    run_job(fill(8'd16), fill(8'd16), 0); wait_idle();
    run_job(fill(8'd2), fill(8'd3), 0); wait_idle();
    rmode = 1;
    run_job(rnd72(), rnd72(), 3); wait_idle();
    rmode = 2;
    repeat (3) begin run_job(rnd72(), rnd72(), $urandom_range(0, 2)); wait_idle(); end
    rmode = 0;
    run_job(rnd72(), rnd72(), 0);
    n = 0;
    while (mm_done && n < 200) begin @(negedge clk); n++; end
    chk("resp_busy", mm_done, 0);
    repeat (5) @(negedge clk);
    do_reset();
    run_job(id, seq, 0); wait_idle();
    base = n_out;
    run_job(rnd72(), rnd72(), 0);
    n = 0;
    while (n_out < base + 4 && n < 500) begin @(negedge clk); n++; end
    chk("four_out", n_out - base, 4);
    do_reset();
    run_job(rnd72(), seq, 1); wait_idle();
    hang = 1;
    run_job(rnd72(), rnd72(), 0);
    @(negedge clk);
    chk("tmo_load", mm_load, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 2000);
    chk("tmo_cycles", n, 1024);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_in_ready", in_ready, 1);
    jobs_out = jobs_in;
    hang = 0;
    @(posedge clk); #1;
    run_job(id, seq, 0); wait_idle();
    chk("err_sticky", err, 1);
    rmode = 2;
    run_job(rnd72(), rnd72(), 0);
    run_job(id, rnd72(), 0);
    wait_idle();
    rmode = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
